weighted_sum: RTL and testbench
===============================

// Module: weighted_sum
// PURPOSE
//  Trainable N-input neuron core; sits directly upstream of the heaviside activation.
//  Forward: holds N signed Q8.8 weights; accepts a vector of unsigned Q0.8 activations;
//    emits their saturated dot product as the activation's 16-bit arg.
//  Backward: consumes the activation's 16-bit feedback; returns per-input error to the
//    previous layer; when en=1, applies a shift-scaled update to each weight.
// PARAMETERS
//  N          4        number of inputs (>=1)
//  W_INIT     16'h0100 reset value of every weight, signed Q8.8 (0x0100 = 1.0)
//  RATE_SHIFT 4        learning-rate shift; update = delta >>> RATE_SHIFT
// PORTS
//  clk      in   1      clock, rising edge
//  rst      in   1      asynchronous, active-high reset
//  en       in   1      training enable: 1 = wait for err after each res, and update weights
//  arg_stb  in   1      input vector valid
//  arg_rdy  out  1      input vector accepted when arg_stb & arg_rdy
//  arg_dat  in   8*N    x[i] = arg_dat[8*i+:8], unsigned Q0.8
//  res_stb  out  1      sum valid
//  res_rdy  in   1      sum accepted
//  res_dat  out  16     signed Q8.8 saturated dot product
//  err_stb  in   1      error valid
//  err_rdy  out  1      error accepted
//  err_dat  in   16     signed Q8.8 error from downstream feedback
//  fbk_stb  out  1      per-input feedback valid
//  fbk_rdy  in   1      feedback accepted
//  fbk_dat  out  16*N   fbk[i] = fbk_dat[16*i+:16], signed Q8.8
// BEHAVIOUR
//  States: ARG -> FWD -> RES -> (en ? ERR -> BWD -> FBK -> ARG : ARG).
//  Reset (async) values:
//    - state=ARG, all weights=W_INIT.
//    - arg_rdy=1; res_stb=0, err_rdy=0, fbk_stb=0.
//    - res_dat=0, fbk_dat=0.
//  ARG: arg_rdy=1. On handshake, latch x[0..N-1] and clear acc -> FWD.
//  FWD: one MAC per cycle, i=0..N-1:
//    - acc += (w[i]*x[i]) >>> 8.
//    - The product is 24b signed, w signed x {1'b0,x}.
//    - acc is 16+$clog2(N)+1 bits and never overflows.
//    - After N cycles: res_dat = sat16(acc) -> RES.
//  Latency: res_stb is high N+1 cycles after the arg handshake cycle.
//  RES: res_stb=1, res_dat stable until res_rdy.
//    - On handshake: en=1 -> ERR; en=0 -> ARG.
//    - en is sampled in the handshake cycle.
//  ERR: err_rdy=1. On handshake, latch err -> BWD.
//    - err is ignored in any other state (err_rdy=0).
//  BWD: one input per cycle, i=0..N-1:
//    - fbk[i] = sat16((err*w[i]) >>> 8), computed with the pre-update w[i].
//    - if en: w[i] = sat16(w[i] + (((err*x[i]) >>> 8) >>> RATE_SHIFT)).
//    - After N cycles -> FBK.
//  FBK: fbk_stb=1, fbk_dat stable until fbk_rdy. On handshake -> ARG.
//  Handshakes:
//    - stb may not drop, and dat may not change, until rdy.
//    - The block never asserts a stb and its own rdy in the same state.
//  Arithmetic:
//    - All shifts are arithmetic (floor).
//    - sat16 clamps to [16'h8000, 16'h7fff]; wrap-around is never allowed.
//  Reset mid-operation:
//    - Outputs return to reset values immediately.
//    - Any partial acc or fbk is discarded.
//    - Weights return to W_INIT, including those already updated in the current BWD.
//  en dropping during BWD: later indices are not updated; earlier updates persist.
// STRUCTURE
//  Package machina_pkg:
//    - typedef logic signed [15:0] fixed_t (Q8.8).
//    - typedef logic [7:0] unit_t (Q0.8).
//    - function sat16.
//    - localparam FRAC = 8.
//  Sub-module sat_mul: fixed_t a, fixed_t/unit_t b -> fixed_t sat((a*b)>>>FRAC).
//  sat_mul is combinational and shared by FWD and BWD through a mux; one instance.
//  Weight RAM is a register array indexed by the state counter.
// TESTING
//  1 N=4, W_INIT=0x0100, x all 0xff, en=0.
//    -> res_dat=0x03fc, res_stb 5 cycles after the arg handshake, return to ARG.
//  2 After 1, en=1, same x, then err=0xff00.
//    -> res=0x03fc.
//    -> fbk[i]=0xff00 for all i.
//    -> each w=0x00f0 (delta -255>>>4 = -16).
//    -> next forward of all-0xff gives res=0x03bc.
//  3 W_INIT=0x7fff, x all 0xff -> res_dat=0x7fff (saturated, not wrapped).
//    Same with W_INIT=0x8000 -> 0x8000.
//  4 res_rdy held low 10 cycles in RES.
//    -> res_stb and res_dat stable; arg_rdy=0; err_rdy=0.
//  5 rst pulsed mid-FWD and mid-BWD.
//    -> outputs return to reset values, weights=W_INIT, arg_rdy=1 next cycle.
//  6 err_stb asserted while in ARG or RES -> err_rdy=0, no weight change.
//    x=0x00 with en=1 and err=0x7fff -> weights unchanged.

Source files
------------

// File: rtl/machina_pkg.sv
// machina_pkg: shared fixed-point types, FSM states and saturation helper
package machina_pkg;
  localparam int FRAC = 8;
  typedef logic signed [15:0] fixed_t;
  typedef logic [7:0] unit_t;
  typedef enum logic [2:0] {ARG, FWD, RES, ERR, BWD, FBK} state_t;
  function automatic fixed_t sat16(input logic signed [39:0] v);
    return v > 40'sd32767 ? 16'sh7fff : v < -40'sd32768 ? 16'sh8000 : fixed_t'(v[15:0]);
  endfunction
endpackage

// File: rtl/sat_mul.sv
// sat_mul: saturated Q8.8 product (a*b)>>>FRAC, b given as a 17-bit signed operand
module sat_mul
  import machina_pkg::*;
(
  input  fixed_t            a,
  input  logic signed [16:0] b,
  output fixed_t            y
);
  logic signed [32:0] p;
  assign p = 33'(a) * 33'(b);
  assign y = sat16(40'(p >>> FRAC));
endmodule

// File: rtl/weighted_sum.sv
// weighted_sum: trainable N-input neuron core, serial MAC forward and serial update backward
module weighted_sum
  import machina_pkg::*;
#(
  parameter int          N          = 4,
  parameter logic [15:0] W_INIT     = 16'h0100,
  parameter int          RATE_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             arg_stb,
  output logic             arg_rdy,
  input  logic [8*N-1:0]   arg_dat,
  output logic             res_stb,
  input  logic             res_rdy,
  output fixed_t           res_dat,
  input  logic             err_stb,
  output logic             err_rdy,
  input  fixed_t           err_dat,
  output logic             fbk_stb,
  input  logic             fbk_rdy,
  output logic [16*N-1:0]  fbk_dat
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int AW = 16 + $clog2(N) + 1;
  state_t st, st_n;
  logic [IW-1:0] idx;
  logic last;
  unit_t x [N];
  fixed_t w [N];
  fixed_t fbk [N];
  fixed_t err_q, res_q, mul_y;
  logic signed [AW-1:0] acc, acc_n;
  logic signed [31:0] ew;
  assign last = idx == IW'(N - 1);
  assign acc_n = acc + AW'(mul_y);
  assign ew = 32'(err_q) * 32'(w[idx]);
  // one multiplier: w*x while summing, err*x while training
  sat_mul u_mul (
    .a(st == FWD ? w[idx] : err_q),
    .b({9'b0, x[idx]}),
    .y(mul_y)
  );
  assign arg_rdy = st == ARG;
  assign res_stb = st == RES;
  assign err_rdy = st == ERR;
  assign fbk_stb = st == FBK;
  assign res_dat = res_q;
  for (genvar i = 0; i < N; i++) begin : g_fbk
    assign fbk_dat[16*i+:16] = fbk[i];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= ARG;
    else st <= st_n;
  always_comb begin
    st_n = st;
    case (st)
      ARG: st_n = arg_stb ? FWD : ARG;
      FWD: st_n = last ? RES : FWD;
      RES: st_n = res_rdy ? (en ? ERR : ARG) : RES;
      ERR: st_n = err_stb ? BWD : ERR;
      BWD: st_n = last ? FBK : BWD;
      FBK: st_n = fbk_rdy ? ARG : FBK;
      default: st_n = ARG;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      acc <= '0;
      res_q <= '0;
      err_q <= '0;
      for (int i = 0; i < N; i++) begin
        x[i] <= '0;
        w[i] <= W_INIT;
        fbk[i] <= '0;
      end
    end else begin
      if (st == ARG && arg_stb) begin
        for (int i = 0; i < N; i++) x[i] <= arg_dat[8*i+:8];
        acc <= '0;
      end
      if (st == FWD) begin
        acc <= acc_n;
        if (last) res_q <= sat16(40'(acc_n));
      end
      if (st == ERR && err_stb) err_q <= err_dat;
      // feedback uses the weight before this cycle's update
      if (st == BWD) begin
        fbk[idx] <= sat16(40'(ew >>> FRAC));
        if (en) w[idx] <= sat16(40'(w[idx]) + 40'(mul_y >>> RATE_SHIFT));
      end
      if (st == FWD || st == BWD) idx <= last ? '0 : idx + 1'b1;
    end
endmodule

// File: tb/tb_weighted_sum.sv
// tb_weighted_sum: directed + random checks of weighted_sum against an integer reference model
module tb_weighted_sum;
  localparam int N = 4;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, en, arg_stb, res_rdy, err_stb, fbk_rdy;
  logic [8*N-1:0] arg_dat;
  logic [15:0] err_dat;
  logic arg_rdy, res_stb, err_rdy, fbk_stb;
  logic [15:0] res_dat;
  logic [16*N-1:0] fbk_dat;
  logic arg_rdy_h, res_stb_h, err_rdy_h, fbk_stb_h;
  logic [15:0] res_dat_h;
  logic [16*N-1:0] fbk_dat_h;
  logic arg_rdy_l, res_stb_l, err_rdy_l, fbk_stb_l;
  logic [15:0] res_dat_l;
  logic [16*N-1:0] fbk_dat_l;
  int n_cmp = 0, n_bad = 0;
  int wm[N];
  int wh[N] = '{default: 32767};
  int wl[N] = '{default: -32768};
  logic [8*N-1:0] xr;
  logic [15:0] er;

  weighted_sum #(.N(N), .W_INIT(16'h0100), .RATE_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .arg_stb(arg_stb), .arg_rdy(arg_rdy), .arg_dat(arg_dat),
    .res_stb(res_stb), .res_rdy(res_rdy), .res_dat(res_dat),
    .err_stb(err_stb), .err_rdy(err_rdy), .err_dat(err_dat),
    .fbk_stb(fbk_stb), .fbk_rdy(fbk_rdy), .fbk_dat(fbk_dat)
  );
  weighted_sum #(.N(N), .W_INIT(16'h7fff), .RATE_SHIFT(4)) dut_h (
    .clk(clk), .rst(rst), .en(1'b0),
    .arg_stb(arg_stb), .arg_rdy(arg_rdy_h), .arg_dat(arg_dat),
    .res_stb(res_stb_h), .res_rdy(res_rdy), .res_dat(res_dat_h),
    .err_stb(1'b0), .err_rdy(err_rdy_h), .err_dat(16'h0000),
    .fbk_stb(fbk_stb_h), .fbk_rdy(1'b0), .fbk_dat(fbk_dat_h)
  );
  weighted_sum #(.N(N), .W_INIT(16'h8000), .RATE_SHIFT(4)) dut_l (
    .clk(clk), .rst(rst), .en(1'b0),
    .arg_stb(arg_stb), .arg_rdy(arg_rdy_l), .arg_dat(arg_dat),
    .res_stb(res_stb_l), .res_rdy(res_rdy), .res_dat(res_dat_l),
    .err_stb(1'b0), .err_rdy(err_rdy_l), .err_dat(16'h0000),
    .fbk_stb(fbk_stb_l), .fbk_rdy(1'b0), .fbk_dat(fbk_dat_l)
  );

  function automatic int sat(input int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  function automatic int dot(input int w[N], input logic [8*N-1:0] xv);
    int s = 0;
    for (int i = 0; i < N; i++) s += (w[i] * int'(xv[8*i+:8])) >>> 8;
    return sat(s);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < N; i++) wm[i] = 256;
  endtask

  task automatic forward(input logic [8*N-1:0] xv, input int hold);
    int c = 0;
    logic [15:0] r;
    arg_dat = xv;
    arg_stb = 1;
    while (!arg_rdy && c < 50) begin tick; c++; end
    chk("arg_rdy", 16'(arg_rdy), 16'd1);
    tick;
    arg_stb = 0;
    c = 0;
    while (!res_stb && c < 50) begin tick; c++; end
    chk("latency", 16'(c), 16'(N));
    chk("res", res_dat, 16'(dot(wm, xv)));
    chk("res_hi", res_dat_h, 16'(dot(wh, xv)));
    chk("res_lo", res_dat_l, 16'(dot(wl, xv)));
    r = res_dat;
    for (int k = 0; k < hold; k++) begin
      tick;
      chk("hold_stb", 16'(res_stb), 16'd1);
      chk("hold_dat", res_dat, r);
      chk("hold_arg_rdy", 16'(arg_rdy), 16'd0);
      chk("hold_err_rdy", 16'(err_rdy), 16'd0);
    end
    res_rdy = 1;
    tick;
    res_rdy = 0;
  endtask

  // keep = number of leading indices trained before en is dropped
  task automatic backward(input logic [8*N-1:0] xv, input logic [15:0] e, input int keep);
    int c = 0;
    int ev;
    int exp_f;
    ev = int'(signed'(e));
    chk("err_rdy", 16'(err_rdy), 16'd1);
    err_dat = e;
    err_stb = 1;
    tick;
    err_stb = 0;
    while (!fbk_stb && c < 50) begin
      if (c == keep) en = 0;
      tick;
      c++;
    end
    chk("bwd_len", 16'(c), 16'(N));
    for (int i = 0; i < N; i++) begin
      exp_f = sat((ev * wm[i]) >>> 8);
      chk($sformatf("fbk%0d", i), fbk_dat[16*i+:16], 16'(exp_f));
      if (i < keep) wm[i] = sat(wm[i] + (((ev * int'(xv[8*i+:8])) >>> 8) >>> 4));
    end
    fbk_rdy = 1;
    tick;
    fbk_rdy = 0;
    chk("fbk_to_arg", 16'(arg_rdy), 16'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1; en = 0; arg_stb = 0; res_rdy = 0; err_stb = 0; fbk_rdy = 0;
    arg_dat = '0; err_dat = '0;
    model_reset;
    tick;
    tick;
    chk("rst_arg_rdy", 16'(arg_rdy), 16'd1);
    chk("rst_res_stb", 16'(res_stb), 16'd0);
    chk("rst_err_rdy", 16'(err_rdy), 16'd0);
    chk("rst_fbk_stb", 16'(fbk_stb), 16'd0);
    chk("rst_res_dat", res_dat, 16'h0000);
    for (int i = 0; i < N; i++) chk($sformatf("rst_fbk%0d", i), fbk_dat[16*i+:16], 16'h0000);
    rst = 0;
    tick;
    // unit weights, full-scale inputs, no training
    forward({N{8'hff}}, 0);
    chk("t1_res", res_dat, 16'h03fc);
    chk("t1_back_to_arg", 16'(arg_rdy), 16'd1);
    chk("t3_hi", res_dat_h, 16'h7fff);
    chk("t3_lo", res_dat_l, 16'h8000);
    // one training step with err = -1.0
    en = 1;
    forward({N{8'hff}}, 0);
    chk("t2_res", res_dat, 16'h03fc);
    backward({N{8'hff}}, 16'hff00, N);
    for (int i = 0; i < N; i++) chk($sformatf("t2_fbk%0d", i), fbk_dat[16*i+:16], 16'hff00);
    en = 0;
    forward({N{8'hff}}, 0);
    chk("t2_res_after", res_dat, 16'h03bc);
    // stalled result
    xr = $urandom;
    forward(xr, 10);
    // stray err_stb outside ERR
    err_dat = 16'($urandom);
    err_stb = 1;
    tick;
    chk("t6_err_rdy_arg", 16'(err_rdy), 16'd0);
    tick;
    forward(xr, 2);
    err_stb = 0;
    forward(xr, 0);
    // zero inputs cannot move weights
    en = 1;
    forward('0, 0);
    backward('0, 16'h7fff, N);
    en = 0;
    forward({N{8'hff}}, 0);
    chk("t6_res_unchanged", res_dat, 16'h03bc);
    // random traffic, including en dropping part way through training
    for (int t = 0; t < 10; t++) begin
      xr = $urandom;
      er = 16'($urandom);
      en = 1'($urandom_range(0, 1));
      forward(xr, 0);
      if (en) backward(xr, er, int'($urandom_range(0, N)));
      en = 0;
    end
    // reset during FWD
    arg_dat = $urandom;
    arg_stb = 1;
    tick;
    arg_stb = 0;
    tick;
    rst = 1;
    #1;
    chk("t5f_arg_rdy", 16'(arg_rdy), 16'd1);
    chk("t5f_res_stb", 16'(res_stb), 16'd0);
    chk("t5f_res_dat", res_dat, 16'h0000);
    tick;
    rst = 0;
    tick;
    model_reset;
    forward({N{8'hff}}, 0);
    chk("t5f_res", res_dat, 16'h03fc);
    // reset during BWD after some weights were already updated
    en = 1;
    forward({N{8'hff}}, 0);
    err_dat = 16'h4000;
    err_stb = 1;
    tick;
    err_stb = 0;
    tick;
    tick;
    rst = 1;
    #1;
    chk("t5b_arg_rdy", 16'(arg_rdy), 16'd1);
    chk("t5b_err_rdy", 16'(err_rdy), 16'd0);
    chk("t5b_fbk_stb", 16'(fbk_stb), 16'd0);
    for (int i = 0; i < N; i++) chk($sformatf("t5b_fbk%0d", i), fbk_dat[16*i+:16], 16'h0000);
    tick;
    rst = 0;
    en = 0;
    tick;
    model_reset;
    forward({N{8'hff}}, 0);
    chk("t5b_res", res_dat, 16'h03fc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
